// File: rtl/alu_execute_unit_if.sv
// Issue and forwarding bus between the reservation station and the execution unit.
interface alu_execute_unit_if;
   logic [41:0] inOperation;
   logic        inOperationValid;
   logic [22:0] forward;
   logic [2:0]  pending;

   modport master (
      output inOperation,
      output inOperationValid,
      input  forward,
      input  pending
   );

   modport slave (
      input  inOperation,
      input  inOperationValid,
      output forward,
      output pending
   );
endinterface

// File: rtl/alu_execute_unit.sv
// Single-lane integer execution unit: single-cycle ALU ops, a two-register multiply
// pipeline and a small result queue that absorbs completion collisions without stalling.
module alu_execute_unit #(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned MUL_LATENCY = 3
) (
   input logic            clk,
   input logic            reset,
   input logic            flush,
   alu_execute_unit_if.slave bus
);
   localparam int unsigned CandN = QUEUE_DEPTH + 2;
   localparam int unsigned CntW  = $clog2(CandN + 1);

   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpSub = 4'h1;
   localparam logic [3:0] OpAnd = 4'h2;
   localparam logic [3:0] OpOr  = 4'h3;
   localparam logic [3:0] OpXor = 4'h4;
   localparam logic [3:0] OpShl = 4'h5;
   localparam logic [3:0] OpShr = 4'h6;
   localparam logic [3:0] OpSlt = 4'h7;
   localparam logic [3:0] OpMul = 4'h8;

   typedef struct packed {
      logic [5:0]  tag;
      logic [15:0] value;
   } result_t;

   logic [3:0]  op;
   logic [5:0]  tag;
   logic [15:0] a, b;
   assign op  = bus.inOperation[41:38];
   assign tag = bus.inOperation[37:32];
   assign a   = bus.inOperation[31:16];
   assign b   = bus.inOperation[15:0];

   logic is_mul, sc_valid;
   assign is_mul   = bus.inOperationValid && (op == OpMul);
   assign sc_valid = bus.inOperationValid && (op != OpMul);

   logic [15:0] sc_value;
   result_t     sc_res;

   // Single-cycle result; reserved opcodes produce zero.
   always_comb begin
      sc_value = 16'h0000;
      case (op)
         OpAdd:   sc_value = a + b;
         OpSub:   sc_value = a - b;
         OpAnd:   sc_value = a & b;
         OpOr:    sc_value = a | b;
         OpXor:   sc_value = a ^ b;
         OpShl:   sc_value = a << b[3:0];
         OpShr:   sc_value = a >> b[3:0];
         OpSlt:   sc_value = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
         default: sc_value = 16'h0000;
      endcase
   end
   assign sc_res = '{tag: tag, value: sc_value};

   // Multiply pipeline: m1 holds operands, m2 holds the finished product.
   logic        m1_valid_q, m2_valid_q;
   logic [5:0]  m1_tag_q;
   logic [15:0] m1_a_q, m1_b_q;
   logic [15:0] m1_prod;
   result_t     m2_q;
   assign m1_prod = m1_a_q * m1_b_q;

   result_t        q_q [QUEUE_DEPTH];
   result_t        q_d [QUEUE_DEPTH];
   logic [CntW-1:0] q_cnt_q, q_cnt_d;
   result_t        cand [CandN];
   logic [CntW-1:0] cand_cnt;
   logic [22:0]    forward_q;
   logic [2:0]     pending_q, pending_d;

   // Candidate list in priority order: queued results, m2 product, this cycle's ALU result.
   // The head goes to forward; everything behind it becomes the next queue.
   always_comb begin
      cand_cnt = q_cnt_q + CntW'(m2_valid_q) + CntW'(sc_valid);
      for (int i = 0; i < CandN; i++) begin
         cand[i] = '0;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (CntW'(i) < q_cnt_q) cand[i] = q_q[i];
      end
      for (int i = 0; i < CandN; i++) begin
         if (m2_valid_q && (CntW'(i) == q_cnt_q)) cand[i] = m2_q;
         if (sc_valid && (CntW'(i) == q_cnt_q + CntW'(m2_valid_q))) cand[i] = sc_res;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         q_d[i] = cand[i + 1];
      end
      if (cand_cnt == '0) begin
         q_cnt_d = '0;
      end else if (cand_cnt - CntW'(1) > CntW'(QUEUE_DEPTH)) begin
         q_cnt_d = CntW'(QUEUE_DEPTH);
      end else begin
         q_cnt_d = cand_cnt - CntW'(1);
      end
      pending_d = 3'(q_cnt_d) + 3'(is_mul) + 3'(m1_valid_q);
   end

   // Control state and registered outputs; reset and flush clear identically.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         m1_valid_q <= 1'b0;
         m2_valid_q <= 1'b0;
         q_cnt_q    <= '0;
         forward_q  <= '0;
         pending_q  <= '0;
      end else begin
         m1_valid_q <= is_mul;
         m2_valid_q <= m1_valid_q;
         q_cnt_q    <= q_cnt_d;
         pending_q  <= pending_d;
         if (cand_cnt != '0) begin
            forward_q <= {1'b1, cand[0]};
         end else begin
            forward_q[22] <= 1'b0;
         end
      end
   end

   // Datapath registers; their contents are qualified by the valids and counts above.
   always_ff @(posedge clk) begin
      if (is_mul) begin
         m1_tag_q <= tag;
         m1_a_q   <= a;
         m1_b_q   <= b;
      end
      m2_q <= '{tag: m1_tag_q, value: m1_prod};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         q_q[i] <= q_d[i];
      end
   end

   assign bus.forward = forward_q;
   assign bus.pending = pending_q;

   // A push into a full queue would silently lose a completion.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
      (cand_cnt <= CntW'(QUEUE_DEPTH + 1)))
      else $error("alu_execute_unit: result queue overflow");

   a_params: assert property (@(posedge clk) (QUEUE_DEPTH >= 3) && (MUL_LATENCY == 3))
      else $error("alu_execute_unit: illegal parameters");
endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: directed operations, expected completions queued with their
// cycle, and an independent monitor that checks the forwarding bus every cycle.
module tb_alu_execute_unit;
   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpSub = 4'h1;
   localparam logic [3:0] OpAnd = 4'h2;
   localparam logic [3:0] OpOr  = 4'h3;
   localparam logic [3:0] OpXor = 4'h4;
   localparam logic [3:0] OpShl = 4'h5;
   localparam logic [3:0] OpShr = 4'h6;
   localparam logic [3:0] OpSlt = 4'h7;
   localparam logic [3:0] OpMul = 4'h8;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   alu_execute_unit_if bus ();

   alu_execute_unit #(
      .QUEUE_DEPTH(4),
      .MUL_LATENCY(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [5:0]  tag;
      logic [15:0] value;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;

   // Back-to-back stream: three muls then three subs.
   logic [3:0]  t4_op  [6] = '{OpMul, OpMul, OpMul, OpSub, OpSub, OpSub};
   logic [15:0] t4_a   [6] = '{16'h0002, 16'h1234, 16'hFFFF, 16'h0000, 16'h1000, 16'h0005};
   logic [15:0] t4_b   [6] = '{16'h0003, 16'h0010, 16'hFFFF, 16'h0001, 16'h0001, 16'h0007};
   int          t4_pend [8] = '{1, 2, 2, 2, 2, 2, 1, 0};

   always @(posedge clk) cyc <= cyc + 1;

   // Forward monitor: valid must match the scoreboard head exactly in its cycle.
   always @(negedge clk) begin
      logic exp_v;
      exp_t e;
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      n_vec++;
      if (bus.forward[22] !== exp_v) begin
         n_fail++;
         $display("FAIL fwd_valid cycle %0d: got valid=%b tag=%0d value=%h, want valid=%b",
                  cyc, bus.forward[22], bus.forward[21:16], bus.forward[15:0], exp_v);
      end
      if (exp_v) begin
         e = sb.pop_front();
         n_vec++;
         if (bus.forward[21:0] !== {e.tag, e.value}) begin
            n_fail++;
            $display("FAIL fwd_data cycle %0d: got tag=%0d value=%h, want tag=%0d value=%h",
                     cyc, bus.forward[21:16], bus.forward[15:0], e.tag, e.value);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [3:0] op, input logic [5:0] tag,
                        input logic [15:0] a, input logic [15:0] b);
      bus.inOperation      = {op, tag, a, b};
      bus.inOperationValid = v;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 6'd0, 16'h0, 16'h0);
   endtask

   task automatic expect_at(input int c, input logic [5:0] tag, input logic [15:0] value);
      exp_t e;
      e.cyc   = c;
      e.tag   = tag;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [22:0] got, input logic [22:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, got, want);
      end
   endtask

   task automatic check_pending(input int want);
      @(negedge clk);
      chk("pending", 23'(bus.pending), 23'(want));
   endtask

   task automatic issue_single(input logic [3:0] op, input logic [5:0] tag,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] want);
      drive(1'b1, op, tag, a, b);
      expect_at(cyc + 1, tag, want);
      tick();
   endtask

   initial begin
      int base;
      reset = 1'b1;
      flush = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_forward", bus.forward, 23'h0);
      chk("reset_pending", 23'(bus.pending), 23'h0);
      tick();

      // add with signed-overflow wrap
      issue_single(OpAdd, 6'd5, 16'h7FFF, 16'h0001, 16'h8000);
      idle();
      tick();
      tick();

      // lone multiply latency and pending
      base = cyc;
      drive(1'b1, OpMul, 6'd9, 16'h0100, 16'h0101);
      expect_at(base + 3, 6'd9, 16'h0100);
      tick();
      idle();
      check_pending(1);
      tick();
      check_pending(1);
      tick();
      check_pending(0);
      tick();
      tick();

      // multiply collides with a later single-cycle op
      base = cyc;
      drive(1'b1, OpMul, 6'd1, 16'h0003, 16'h0005);
      expect_at(base + 3, 6'd1, 16'h000F);
      tick();
      idle();
      tick();
      drive(1'b1, OpXor, 6'd2, 16'hF0F0, 16'h0FF0);
      expect_at(base + 4, 6'd2, 16'hFF00);
      tick();
      idle();
      tick();
      tick();
      tick();

      // back-to-back: younger sub 4 overtakes mul 3 through the queue
      base = cyc;
      expect_at(base + 3, 6'd1, 16'h0006);
      expect_at(base + 4, 6'd2, 16'h2340);
      expect_at(base + 5, 6'd4, 16'hFFFF);
      expect_at(base + 6, 6'd3, 16'h0001);
      expect_at(base + 7, 6'd5, 16'h0FFF);
      expect_at(base + 8, 6'd6, 16'hFFFE);
      for (int k = 0; k < 9; k++) begin
         if (k < 6) drive(1'b1, t4_op[k], 6'(k + 1), t4_a[k], t4_b[k]);
         else idle();
         if (k >= 1) check_pending(t4_pend[k - 1]);
         tick();
      end
      idle();
      tick();
      tick();

      // flush kills an in-flight mul and the op presented with it
      base = cyc;
      drive(1'b1, OpMul, 6'd7, 16'h0003, 16'h0003);
      tick();
      flush = 1'b1;
      drive(1'b1, OpAdd, 6'd10, 16'h0001, 16'h0001);
      check_pending(1);
      tick();
      flush = 1'b0;
      drive(1'b1, OpAdd, 6'd11, 16'h0001, 16'h0002);
      expect_at(base + 3, 6'd11, 16'h0003);
      check_pending(0);
      tick();
      idle();
      tick();
      tick();
      tick();

      // remaining ALU ops, including B[3:0] shift masking and a reserved opcode
      issue_single(OpSlt, 6'd12, 16'hFFFF, 16'h0001, 16'h0001);
      issue_single(OpShr, 6'd13, 16'h8000, 16'h0013, 16'h1000);
      issue_single(4'hB,  6'd14, 16'h1234, 16'h5678, 16'h0000);
      issue_single(OpShl, 6'd15, 16'h0001, 16'h0014, 16'h0010);
      issue_single(OpAnd, 6'd16, 16'hF0F0, 16'h0FF0, 16'h00F0);
      issue_single(OpOr,  6'd17, 16'hF0F0, 16'h0FF0, 16'hFFF0);
      issue_single(OpSlt, 6'd18, 16'h0001, 16'hFFFF, 16'h0000);
      idle();
      tick();
      tick();

      // reset plus flush with a populated queue drops everything queued
      base = cyc;
      expect_at(base + 3, 6'd1, 16'h0006);
      expect_at(base + 4, 6'd2, 16'h2340);
      expect_at(base + 5, 6'd4, 16'hFFFF);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, t4_op[k], 6'(k + 1), t4_a[k], t4_b[k]);
         tick();
      end
      reset = 1'b1;
      flush = 1'b1;
      drive(1'b1, t4_op[5], 6'd6, t4_a[5], t4_b[5]);
      check_pending(2);
      tick();
      reset = 1'b0;
      flush = 1'b0;
      idle();
      check_pending(0);
      tick();
      tick();
      tick();
      tick();

      chk("scoreboard_drained", 23'(sb.size()), 23'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
